// File: rtl/modport_mem_pkg.sv
// Shared constants and types for the modport_mem register block.
// Offsets, reset values, CTRL mask and the register-select enum.
package modport_mem_pkg;

  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] REG1_OFS   = 8'h04;
  localparam logic [7:0] REG2_OFS   = 8'h08;
  localparam logic [7:0] REG3_OFS   = 8'h0C;
  localparam logic [7:0] STATUS_OFS = 8'h10;
  localparam logic [7:0] ID_OFS     = 8'h14;

  localparam logic [31:0] CTRL_RST  = 32'h0000_0000;
  localparam logic [31:0] REG_RST   = 32'h0000_0000;
  localparam logic [15:0] WCNT_RST  = 16'h0000;
  localparam logic        ERR_RST   = 1'b0;
  localparam logic [31:0] RDATA_RST = 32'h0000_0000;

  localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;
  localparam logic [15:0] WCNT_MAX  = 16'hFFFF;
  localparam int          ERR_BIT   = 16;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_REG1,
    SEL_REG2,
    SEL_REG3,
    SEL_STATUS,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

  // STATUS layout: [31:17] zero, [16] sticky error, [15:0] write count.
  function automatic logic [31:0] pack_status(
    input logic [15:0] cnt,
    input logic        err
  );
    return {15'b0, err, cnt};
  endfunction

endpackage

// File: rtl/modport_mem_decode.sv
// Combinational address decoder for modport_mem.
// In: addr. Out: sel, mapped, aligned, ro. ID mapped only with MODPORT_MEM_ID_REG_EN.
module modport_mem_decode
  import modport_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0] addr,
  output reg_sel_e    sel,
  output logic        mapped,
  output logic        aligned,
  output logic        ro
);

  logic       in_win;
  logic [5:0] word;

  assign in_win  = (addr[31:8] == BASE_ADDR[31:8]);
  assign word    = addr[7:2];
  assign aligned = (addr[1:0] == 2'b00);

  always_comb begin
    sel = SEL_NONE;
    if (in_win) begin
      unique case (1'b1)
        (word == CTRL_OFS[7:2]):   sel = SEL_CTRL;
        (word == REG1_OFS[7:2]):   sel = SEL_REG1;
        (word == REG2_OFS[7:2]):   sel = SEL_REG2;
        (word == REG3_OFS[7:2]):   sel = SEL_REG3;
        (word == STATUS_OFS[7:2]): sel = SEL_STATUS;
`ifdef MODPORT_MEM_ID_REG_EN
        (word == ID_OFS[7:2]):     sel = SEL_ID;
`endif
        default:                   sel = SEL_NONE;
      endcase
    end
  end

  assign mapped = (sel != SEL_NONE);
  assign ro     = (sel == SEL_STATUS) || (sel == SEL_ID);

endmodule

// File: rtl/modport_mem.sv
// Small memory-mapped register block: CTRL, REG1-3, STATUS, optional ID.
// Ports: clk, rst (sync high), addr, wr_en, valid, wdata, rdata. Macro: MODPORT_MEM_ID_REG_EN.
module modport_mem
  import modport_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h4D50_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        valid,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  reg_sel_e    sel;
  logic        mapped;
  logic        aligned;
  logic        ro;

  logic [31:0] ctrl_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  logic [31:0] reg3_q;
  logic [15:0] wcnt_q;
  logic        err_q;

  logic        good;
  logic        rd_acc;
  logic        rw_wr;
  logic        w1c;
  logic        err_set;
  logic        err_d;
  logic [31:0] rd_val;

  modport_mem_decode #(
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr    (addr),
    .sel     (sel),
    .mapped  (mapped),
    .aligned (aligned),
    .ro      (ro)
  );

  always_comb begin
    good   = mapped && aligned;
    rd_acc = valid && !wr_en;
    rw_wr  = valid && wr_en && good && !ro;
    w1c    = valid && wr_en && good &&
             (sel == SEL_STATUS) && wdata[ERR_BIT];
    // STATUS itself is RO but writable for W1C, so it is not an error.
    err_set = valid && (!good ||
              (wr_en && ro && (sel != SEL_STATUS)));
    err_d = err_q;
    if (w1c)
      err_d = 1'b0;
    if (err_set)
      err_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    if (good) begin
      unique case (sel)
        SEL_CTRL:   rd_val = ctrl_q;
        SEL_REG1:   rd_val = reg1_q;
        SEL_REG2:   rd_val = reg2_q;
        SEL_REG3:   rd_val = reg3_q;
        SEL_STATUS: rd_val = pack_status(wcnt_q, err_q);
`ifdef MODPORT_MEM_ID_REG_EN
        SEL_ID:     rd_val = ID_VALUE;
`endif
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CTRL_RST;
      reg1_q <= REG_RST;
      reg2_q <= REG_RST;
      reg3_q <= REG_RST;
      wcnt_q <= WCNT_RST;
      err_q  <= ERR_RST;
    end else begin
      if (rw_wr) begin
        unique case (sel)
          SEL_CTRL: ctrl_q <= wdata & CTRL_MASK;
          SEL_REG1: reg1_q <= wdata;
          SEL_REG2: reg2_q <= wdata;
          SEL_REG3: reg3_q <= wdata;
          default:  ;
        endcase
      end
      if (rw_wr && (wcnt_q != WCNT_MAX))
        wcnt_q <= wcnt_q + 16'd1;
      err_q <= err_d;
    end
  end

  // Unmapped/unaligned reads return zero via rd_val's default.
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= RDATA_RST;
    else if (rd_acc)
      rdata <= rd_val;
  end

endmodule

// File: tb/tb_modport_mem.sv
// Scoreboard testbench for modport_mem.
// Directed accesses push expectations; a monitor pops and compares.
module tb_modport_mem;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic        valid;
  logic [31:0] wdata;
  logic [31:0] rdata;

  typedef struct {
    logic [31:0] a;
    logic [31:0] e;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  logic [31:0] last_rdata;
  logic [31:0] id_exp;
  logic [31:0] id_stat;

  modport_mem u_dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wr_en (wr_en),
    .valid (valid),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1;
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_t x;
    x.a   = a;
    x.e   = e;
    valid = 1'b1;
    wr_en = 1'b0;
    addr  = a;
    wdata = 32'h0;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: reads are scored against the queue; writes must hold rdata.
  always @(posedge clk) begin
    logic was_rd;
    logic was_wr;
    exp_t x;
    was_rd = valid && !wr_en && !rst;
    was_wr = valid && wr_en && !rst;
    #1;
    if (was_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h want=none", rdata);
      end else begin
        x = exp_q.pop_front();
        if (rdata !== x.e) begin
          errors++;
          $display("FAIL read@%h got=%h want=%h", x.a, rdata, x.e);
        end
      end
    end else if (was_wr) begin
      checks++;
      if (rdata !== last_rdata) begin
        errors++;
        $display("FAIL hold_on_write got=%h want=%h",
                 rdata, last_rdata);
      end
    end
    last_rdata = rdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
`ifdef MODPORT_MEM_ID_REG_EN
    id_exp  = 32'h4D50_0001;
    id_stat = 32'h0000_0004;
`else
    id_exp  = 32'h0000_0000;
    id_stat = 32'h0001_0004;
`endif
    rst   = 1'b1;
    valid = 1'b0;
    wr_en = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    rd(32'h00, 32'h0);
    rd(32'h04, 32'h0);
    rd(32'h08, 32'h0);
    rd(32'h0C, 32'h0);
    rd(32'h10, 32'h0);

    wr(32'h04, 32'hA5A5_1234);
    rd(32'h04, 32'hA5A5_1234);
    rd(32'h10, 32'h0000_0001);

    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00, 32'h0000_00FF);
    rd(32'h10, 32'h0000_0002);

    wr(32'h08, 32'h1111_2222);
    wr(32'h0C, 32'h3333_4444);
    valid = 1'b0;
    wr_en = 1'b1;
    addr  = 32'h04;
    wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #2;
    rd(32'h08, 32'h1111_2222);
    rd(32'h0C, 32'h3333_4444);
    rd(32'h04, 32'hA5A5_1234);
    rd(32'h10, 32'h0000_0004);

    wr(32'h100, 32'h0000_0001);
    rd(32'h10, 32'h0001_0004);
    rd(32'h04, 32'hA5A5_1234);
    wr(32'h10, 32'h0001_0000);
    rd(32'h10, 32'h0000_0004);

    rd(32'h06, 32'h0);
    rd(32'h10, 32'h0001_0004);
    wr(32'h10, 32'h0001_0000);
    wr(32'h10, 32'h0000_FFFF);
    rd(32'h10, 32'h0000_0004);

    wr(32'h14, 32'h0000_0005);
    rd(32'h10, 32'h0001_0004);
    wr(32'h10, 32'h0001_0000);
    rd(32'h14, id_exp);
    rd(32'h10, id_stat);

    rst   = 1'b1;
    valid = 1'b1;
    wr_en = 1'b1;
    addr  = 32'h08;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    rst = 1'b0;
    rd(32'h08, 32'h0);
    rd(32'h10, 32'h0);
    rd(32'h00, 32'h0);

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
